// File: rtl/message_stream_splitter_pkg.sv
// Shared framing constants and state encoding for the message stream combiner/splitter pair.
package message_stream_splitter_pkg;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_RESYNC  = 2'd2
    } split_state_e;

    // Length field sits at the bottom of the header word, index directly above it.
    localparam int LEN_LSB = 0;

    function automatic int hdr_flag_pos(input int wdth);
        return wdth - 1;
    endfunction

    function automatic int idx_lsb(input int len_width);
        return len_width;
    endfunction

endpackage

// File: rtl/message_stream_splitter_if.sv
// Combined-stream input and per-lane output bundle of the splitter.
interface message_stream_splitter_if #(
    parameter int N_STREAMS = 2,
    parameter int WDTH      = 32
);
    logic [WDTH-1:0]           in_data;
    logic                      in_nd;
    logic [N_STREAMS*WDTH-1:0] out_data;
    logic [N_STREAMS-1:0]      out_nd;
    logic                      error;

    modport master (
        output in_data,
        output in_nd,
        input  out_data,
        input  out_nd,
        input  error
    );

    modport slave (
        input  in_data,
        input  in_nd,
        output out_data,
        output out_nd,
        output error
    );
endinterface

// File: rtl/message_stream_splitter_header_decode.sv
// Combinational header field extraction and validity check (message_header_decode).
module message_header_decode #(
    parameter int N_STREAMS         = 2,
    parameter int LOG_N_STREAMS     = 1,
    parameter int MAX_PACKET_LENGTH = 16,
    parameter int MSG_LENGTH_WIDTH  = 5
) (
    input  logic                                      hdr_flag,
    input  logic [MSG_LENGTH_WIDTH+LOG_N_STREAMS-1:0] hdr_fields,
    output logic [LOG_N_STREAMS-1:0]                  hdr_index,
    output logic [MSG_LENGTH_WIDTH-1:0]               hdr_length,
    output logic                                      header_valid
);

    // Split index/length and qualify against lane count and length bounds.
    always_comb begin
        hdr_length   = hdr_fields[MSG_LENGTH_WIDTH-1:0];
        hdr_index    = hdr_fields[MSG_LENGTH_WIDTH +: LOG_N_STREAMS];
        header_valid = hdr_flag
                    && (32'(hdr_index) < 32'(N_STREAMS))
                    && (hdr_length != {MSG_LENGTH_WIDTH{1'b0}})
                    && (32'(hdr_length) <= 32'(MAX_PACKET_LENGTH));
    end

endmodule

// File: rtl/message_stream_splitter.sv
// Demultiplexes a combined header+payload word stream onto N_STREAMS lanes with framing-error flag.
// Optional build macro SPLITTER_FORWARD_HEADER_EN: also emit valid header words on their lane.
module message_stream_splitter
    import message_stream_splitter_pkg::*;
#(
    parameter int N_STREAMS         = 2,
    parameter int LOG_N_STREAMS     = 1,
    parameter int WDTH              = 32,
    parameter int MAX_PACKET_LENGTH = 16,
    parameter int MSG_LENGTH_WIDTH  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    message_stream_splitter_if.slave bus
);

    localparam int FLAG_POS = hdr_flag_pos(WDTH);
    localparam int IDX_LSB  = idx_lsb(MSG_LENGTH_WIDTH);

    split_state_e                  state_q, state_d;
    logic [MSG_LENGTH_WIDTH-1:0]   rem_q, rem_d;
    logic [LOG_N_STREAMS-1:0]      lane_q, lane_d;
    logic [N_STREAMS*WDTH-1:0]     out_data_q, out_data_d;
    logic [N_STREAMS-1:0]          out_nd_q, out_nd_d;
    logic                          error_q, error_d;

    logic                          hdr_flag_s;
    logic [LOG_N_STREAMS-1:0]      hdr_index_s;
    logic [MSG_LENGTH_WIDTH-1:0]   hdr_length_s;
    logic                          header_valid_s;
    logic                          hdr_seen_s;
    logic                          accept_hdr_s;
    logic                          hdr_error_s;
    logic                          fwd_payload_s;

    assign hdr_flag_s = bus.in_data[FLAG_POS];

    message_header_decode #(
        .N_STREAMS         (N_STREAMS),
        .LOG_N_STREAMS     (LOG_N_STREAMS),
        .MAX_PACKET_LENGTH (MAX_PACKET_LENGTH),
        .MSG_LENGTH_WIDTH  (MSG_LENGTH_WIDTH)
    ) u_hdr_decode (
        .hdr_flag     (hdr_flag_s),
        .hdr_fields   (bus.in_data[IDX_LSB+LOG_N_STREAMS-1:0]),
        .hdr_index    (hdr_index_s),
        .hdr_length   (hdr_length_s),
        .header_valid (header_valid_s)
    );

    // Classify the incoming word: in RESYNC only flagged words are considered headers.
    always_comb begin
        hdr_seen_s    = 1'b0;
        fwd_payload_s = 1'b0;
        case (state_q)
            ST_HEADER:  hdr_seen_s    = bus.in_nd;
            ST_RESYNC:  hdr_seen_s    = bus.in_nd && hdr_flag_s;
            ST_PAYLOAD: fwd_payload_s = bus.in_nd;
            default: begin
                hdr_seen_s    = 1'b0;
                fwd_payload_s = 1'b0;
            end
        endcase
        accept_hdr_s = hdr_seen_s && header_valid_s;
        hdr_error_s  = hdr_seen_s && !header_valid_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HEADER;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HEADER, ST_RESYNC: begin
                if (accept_hdr_s) begin
                    state_d = ST_PAYLOAD;
                end else if (hdr_error_s) begin
                    state_d = ST_RESYNC;
                end else begin
                    state_d = state_q;
                end
            end
            ST_PAYLOAD: begin
                if (fwd_payload_s && (rem_q == MSG_LENGTH_WIDTH'(1))) begin
                    state_d = ST_HEADER;
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            default: state_d = ST_HEADER;
        endcase
    end

    // Counter, lane latch, sticky error and lane outputs.
    always_comb begin
        rem_d      = rem_q;
        lane_d     = lane_q;
        error_d    = error_q;
        out_nd_d   = {N_STREAMS{1'b0}};
        out_data_d = out_data_q;

        if (accept_hdr_s) begin
            rem_d  = hdr_length_s;
            lane_d = hdr_index_s;
        end else if (fwd_payload_s) begin
            rem_d = rem_q - MSG_LENGTH_WIDTH'(1);
        end else begin
            rem_d = rem_q;
        end

        if (hdr_error_s) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end

        for (int k = 0; k < N_STREAMS; k++) begin
            if (fwd_payload_s && (lane_q == LOG_N_STREAMS'(k))) begin
                out_nd_d[k]                 = 1'b1;
                out_data_d[k*WDTH +: WDTH]  = bus.in_data;
`ifdef SPLITTER_FORWARD_HEADER_EN
            end else if (accept_hdr_s && (hdr_index_s == LOG_N_STREAMS'(k))) begin
                out_nd_d[k]                 = 1'b1;
                out_data_d[k*WDTH +: WDTH]  = bus.in_data;
`endif
            end else begin
                out_nd_d[k] = 1'b0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q      <= {MSG_LENGTH_WIDTH{1'b0}};
            lane_q     <= {LOG_N_STREAMS{1'b0}};
            error_q    <= 1'b0;
            out_nd_q   <= {N_STREAMS{1'b0}};
            out_data_q <= {(N_STREAMS*WDTH){1'b0}};
        end else begin
            rem_q      <= rem_d;
            lane_q     <= lane_d;
            error_q    <= error_d;
            out_nd_q   <= out_nd_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.out_data = out_data_q;
    assign bus.out_nd   = out_nd_q;
    assign bus.error    = error_q;

endmodule
